// File: rtl/alu_pkg.sv
// Shared types for the fm2030 ALU: operation codes and the condition-flag bundle.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_SHL = 2'd2,
    ALU_SHR = 2'd3
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_shifter.sv
// Logical barrel shifter with zero fill. It reports the last bit shifted out,
// and any amount above WIDTH saturates the result and the carry to zero.
module alu_shifter #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] amount,
  input  logic             direction,  // 0 = left, 1 = right
  output logic [WIDTH-1:0] shifted,
  output logic             shift_out
);
  localparam int AW = $clog2(WIDTH);

  logic [AW:0]        sh;
  logic [2*WIDTH-1:0] wide_l;
  logic [2*WIDTH-1:0] wide_r;

  // The data sits in a double-width window. The bit next to the result field
  // is the last one shifted out. For sh == 0 that bit is naturally 0.
  always_comb begin
    sh        = amount[AW:0];
    wide_l    = {{WIDTH{1'b0}}, data} << sh;
    wide_r    = {data, {WIDTH{1'b0}}} >> sh;
    shifted   = '0;
    shift_out = 1'b0;
    if (32'(amount) <= WIDTH) begin
      if (direction) begin
        shifted   = wide_r[2*WIDTH-1:WIDTH];
        shift_out = wide_r[WIDTH-1];
      end else begin
        shifted   = wide_l[WIDTH-1:0];
        shift_out = wide_l[WIDTH];
      end
    end
  end

endmodule

// File: rtl/alu.sv
// fm2030 datapath ALU. It has a combinational add/sub/shift result and
// registered condition flags that are captured when flags_en is high.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] r0_rd,
  input  logic [WIDTH-1:0] rs,
  input  logic [1:0]       control,
  input  logic             flags_en,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);

  alu_op_e     op;
  logic        is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic        cout;
  logic        add_v;
  logic [WIDTH-1:0] sh_data;
  logic        sh_out;
  alu_flags_t  nxt_flags;
  alu_flags_t  flags;

  assign op     = alu_op_e'(control);
  assign is_sub = (op == ALU_SUB);

  // A single adder serves both ADD and SUB. SUB is done as a + ~b + 1,
  // so the carry out is the unsigned no-borrow indication.
  always_comb begin
    b_eff       = is_sub ? ~rs : rs;
    {cout, sum} = {1'b0, r0_rd} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    add_v       = (r0_rd[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != r0_rd[WIDTH-1]);
  end

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .data      (r0_rd),
    .amount    (rs),
    .direction (control[0]),
    .shifted   (sh_data),
    .shift_out (sh_out)
  );

  // Select the result and derive the condition codes for the current inputs.
  always_comb begin
    result      = sum;
    nxt_flags.c = cout;
    nxt_flags.v = add_v;
    if (op == ALU_SHL || op == ALU_SHR) begin
      result      = sh_data;
      nxt_flags.c = sh_out;
      nxt_flags.v = 1'b0;
    end
    nxt_flags.z = (result == '0);
    nxt_flags.n = result[WIDTH-1];
  end

  // Flag file: cleared asynchronously, loaded only when flags_en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        flags <= '0;
    else if (flags_en) flags <= nxt_flags;
  end

  assign flag_z = flags.z;
  assign flag_c = flags.c;
  assign flag_n = flags.n;
  assign flag_v = flags.v;

endmodule

// File: tb/tb_alu.sv
// Directed and sweep bench for alu. Flags are compared as {z,c,n,v}.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] r0_rd, rs;
  logic [1:0] control;
  logic       flags_en;
  logic [7:0] result;
  logic       flag_z, flag_c, flag_n, flag_v;

  int checks = 0;
  int failures = 0;

  alu dut (
    .clk(clk), .rst_n(rst_n), .r0_rd(r0_rd), .rs(rs), .control(control),
    .flags_en(flags_en), .result(result),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  // Independent reference. It uses wide arithmetic and shifts of a widened window.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                                output logic [7:0] r, output logic [3:0] f);
    logic [8:0]  s;
    logic [15:0] t;
    logic c, v;
    c = 1'b0; v = 1'b0; r = 8'h00;
    case (op)
      2'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                  v = (a[7] == b[7]) && (r[7] != a[7]); end
      2'd1: begin r = a - b; c = (a >= b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      2'd2: begin
              if (b != 0 && b <= 8) begin t = {8'h00, a} << b; r = t[7:0]; c = t[8]; end
              else if (b == 0) r = a;
            end
      default: begin
              if (b != 0 && b <= 8) begin t = {a, 8'h00} >> b; r = t[15:8]; c = t[7]; end
              else if (b == 0) r = a;
            end
    endcase
    f = {(r == 8'h00), c, r[7], v};
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input logic en);
    @(negedge clk);
    r0_rd = a; rs = b; control = op; flags_en = en;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; r0_rd = 8'd3; rs = 8'd3; control = 2'd0; flags_en = 1'b1;
    #2;
    checks++;
    if ({flag_z, flag_c, flag_n, flag_v} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {flag_z, flag_c, flag_n, flag_v});
    end
    checks++;
    if (result !== 8'd6) begin failures++; $display("FAIL reset_result got=%h exp=06", result); end
    @(posedge clk); #1;
    checks++;
    if ({flag_z, flag_c, flag_n, flag_v} !== 4'b0000) begin
      failures++; $display("FAIL reset_hold got=%b exp=0000", {flag_z, flag_c, flag_n, flag_v});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] a  [4] = '{8'd3, 8'd3, 8'd3, 8'd1};
    logic [7:0] b  [4] = '{8'd3, 8'd3, 8'd2, 8'd0};
    logic [1:0] op [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [7:0] er [4] = '{8'd6, 8'd0, 8'd12, 8'd1};
    logic [3:0] ef [4] = '{4'b0000, 4'b1100, 4'b0000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      drive(a[i], b[i], op[i], 1'b1);
      #1; checks++;
      if (result !== er[i]) begin failures++; $display("FAIL basic_result[%0d] got=%h exp=%h", i, result, er[i]); end
      @(posedge clk); #1; checks++;
      if ({flag_z, flag_c, flag_n, flag_v} !== ef[i]) begin
        failures++; $display("FAIL basic_flags[%0d] got=%b exp=%b", i, {flag_z, flag_c, flag_n, flag_v}, ef[i]);
      end
    end
  endtask

  task automatic test_arith_edges();
    logic [7:0] a  [4] = '{8'hFF, 8'h7F, 8'h00, 8'h80};
    logic [7:0] b  [4] = '{8'h01, 8'h01, 8'h01, 8'h01};
    logic [1:0] op [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic [7:0] er [4] = '{8'h00, 8'h80, 8'hFF, 8'h7F};
    logic [3:0] ef [4] = '{4'b1100, 4'b0011, 4'b0010, 4'b0101};
    for (int i = 0; i < 4; i++) begin
      drive(a[i], b[i], op[i], 1'b1);
      #1; checks++;
      if (result !== er[i]) begin failures++; $display("FAIL arith_result[%0d] got=%h exp=%h", i, result, er[i]); end
      @(posedge clk); #1; checks++;
      if ({flag_z, flag_c, flag_n, flag_v} !== ef[i]) begin
        failures++; $display("FAIL arith_flags[%0d] got=%b exp=%b", i, {flag_z, flag_c, flag_n, flag_v}, ef[i]);
      end
    end
  endtask

  task automatic test_shift_edges();
    logic [7:0] a  [6] = '{8'h81, 8'h81, 8'hFF, 8'hFF, 8'hFF, 8'h80};
    logic [7:0] b  [6] = '{8'd1, 8'd1, 8'd8, 8'd9, 8'd8, 8'd7};
    logic [1:0] op [6] = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [7:0] er [6] = '{8'h02, 8'h40, 8'h00, 8'h00, 8'h00, 8'h01};
    logic [3:0] ef [6] = '{4'b0100, 4'b0100, 4'b1100, 4'b1000, 4'b1100, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      drive(a[i], b[i], op[i], 1'b1);
      #1; checks++;
      if (result !== er[i]) begin failures++; $display("FAIL shift_result[%0d] got=%h exp=%h", i, result, er[i]); end
      @(posedge clk); #1; checks++;
      if ({flag_z, flag_c, flag_n, flag_v} !== ef[i]) begin
        failures++; $display("FAIL shift_flags[%0d] got=%b exp=%b", i, {flag_z, flag_c, flag_n, flag_v}, ef[i]);
      end
    end
  endtask

  task automatic test_flag_hold();
    drive(8'd5, 8'd5, 2'd1, 1'b1);
    @(posedge clk); #1; checks++;
    if ({flag_z, flag_c, flag_n, flag_v} !== 4'b1100) begin
      failures++; $display("FAIL hold_capture got=%b exp=1100", {flag_z, flag_c, flag_n, flag_v});
    end
    drive(8'd1, 8'd1, 2'd0, 1'b0);
    #1; checks++;
    if (result !== 8'd2) begin failures++; $display("FAIL hold_result got=%h exp=02", result); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; checks++;
      if ({flag_z, flag_c, flag_n, flag_v} !== 4'b1100) begin
        failures++; $display("FAIL hold_edge[%0d] got=%b exp=1100", i, {flag_z, flag_c, flag_n, flag_v});
      end
    end
  endtask

  task automatic test_async_reset();
    // Flags are 1100 from the hold test and the inputs still present 1 + 1.
    @(negedge clk); #2;
    flags_en = 1'b1;
    rst_n = 1'b0;
    #1; checks++;
    if ({flag_z, flag_c, flag_n, flag_v} !== 4'b0000) begin
      failures++; $display("FAIL async_clear got=%b exp=0000", {flag_z, flag_c, flag_n, flag_v});
    end
    checks++;
    if (result !== 8'd2) begin failures++; $display("FAIL async_result got=%h exp=02", result); end
    @(posedge clk); #1; checks++;
    if ({flag_z, flag_c, flag_n, flag_v} !== 4'b0000) begin
      failures++; $display("FAIL async_held got=%b exp=0000", {flag_z, flag_c, flag_n, flag_v});
    end
    // Release with a negative result presented, so the first capture is visible.
    @(negedge clk); rst_n = 1'b1; r0_rd = 8'h00; rs = 8'h01; control = 2'd1;
    @(posedge clk); #1; checks++;
    if ({flag_z, flag_c, flag_n, flag_v} !== 4'b0010) begin
      failures++; $display("FAIL release_capture got=%b exp=0010", {flag_z, flag_c, flag_n, flag_v});
    end
  endtask

  task automatic test_result_sweep();
    logic [7:0] er;
    logic [3:0] ef;
    flags_en = 1'b0;
    for (int op = 0; op < 4; op++)
      for (int a = 0; a < 256; a++)
        for (int b = 0; b < 256; b++) begin
          r0_rd = 8'(a); rs = 8'(b); control = 2'(op);
          #1;
          model(8'(a), 8'(b), 2'(op), er, ef);
          checks++;
          if (result !== er) begin
            failures++; $display("FAIL sweep_result op=%0d a=%h b=%h got=%h exp=%h", op, a, b, result, er);
          end
        end
  endtask

  task automatic test_flag_sweep();
    logic [7:0] a, b, er;
    logic [1:0] op;
    logic [3:0] ef;
    for (int i = 0; i < 3000; i++) begin
      a = 8'($urandom); op = 2'($urandom);
      b = (op[1] && i[0]) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      drive(a, b, op, 1'b1);
      model(a, b, op, er, ef);
      @(posedge clk); #1; checks++;
      if ({flag_z, flag_c, flag_n, flag_v} !== ef) begin
        failures++; $display("FAIL sweep_flags op=%0d a=%h b=%h got=%b exp=%b", op, a, b, {flag_z, flag_c, flag_n, flag_v}, ef);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith_edges();
    test_shift_edges();
    test_flag_hold();
    test_async_reset();
    test_result_sweep();
    test_flag_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
